// File: rtl/cpu_ctrl_pkg.sv
// Shared control constants for the multicycle 16-bit core: run-control state
// encoding, opcode classes and step numbers.
package cpu_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam logic [4:0] OP_SYS  = 5'b11100;
    localparam logic [4:0] OP_ST   = 5'b00101;
    localparam logic [4:0] OP_GRP6 = 5'b00110;
    localparam logic [4:0] OP_LD0  = 5'b00011;
    localparam logic [4:0] OP_LD1  = 5'b00100;

    // Sub-opcodes carried in instruction bits [1:0].
    localparam logic [1:0] SYS_HALT = 2'b01;
    localparam logic [1:0] GRP6_CMP = 2'b01;
    localparam logic [1:0] GRP6_ST  = 2'b00;

    localparam logic [2:0] STEP_FETCH = 3'd0;
    localparam logic [2:0] STEP_DEC   = 3'd1;
    localparam logic [2:0] STEP_EXE   = 3'd2;
    localparam logic [2:0] STEP_MEM   = 3'd3;
    localparam logic [2:0] STEP_WB    = 3'd4;
    localparam logic [2:0] STEP_BAD   = 3'd7;

    typedef struct packed {
        logic [2:0] last_step;
        logic       is_mem;
        logic       is_halt;
    } step_info_t;

    // Jumps and branches occupy the whole upper opcode half except the SYS group.
    function automatic logic is_jump_class(input logic [4:0] ins_m);
        return ins_m[4] && (ins_m != OP_SYS);
    endfunction

endpackage

// File: rtl/last_step_lut.sv
// Decodes the final step number and memory/halt class of the instruction
// held in the instruction register.
module last_step_lut
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] InsM,
    input  logic [1:0] InsL,
    output logic [2:0] LastStep,
    output logic       IsMem,
    output logic       IsHalt
);

    step_info_t info;

    always_comb begin
        info.last_step = STEP_WB;
        info.is_mem    = 1'b0;
        info.is_halt   = 1'b0;
        if (InsM == OP_SYS) begin
            if (InsL == SYS_HALT) begin
                info.last_step = STEP_EXE;
                info.is_halt   = 1'b1;
            end else begin
                info.last_step = STEP_DEC;
            end
        end else if (is_jump_class(InsM)) begin
            info.last_step = STEP_DEC;
        end else if ((InsM == OP_GRP6) && (InsL == GRP6_CMP)) begin
            info.last_step = STEP_EXE;
        end else if ((InsM == OP_ST) || ((InsM == OP_GRP6) && (InsL == GRP6_ST))) begin
            info.last_step = STEP_MEM;
            info.is_mem    = 1'b1;
        end else if ((InsM == OP_LD0) || (InsM == OP_LD1)) begin
            info.last_step = STEP_WB;
            info.is_mem    = 1'b1;
        end
    end

    assign LastStep = info.last_step;
    assign IsMem    = info.is_mem;
    assign IsHalt   = info.is_halt;

endmodule

// File: rtl/step_sequencer.sv
// Per-instruction step counter with halt/resume/single-step run control and
// a retired-instruction counter.
module step_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    input  logic                StepMode,
    input  logic                StepReq,
    input  logic                MemReady,
    input  logic [4:0]          InsM,
    input  logic [1:0]          InsL,
    output logic [2:0]          Cnt,
    output logic                Running,
    output logic                Halted,
    output logic                Retire,
    output logic [RETIRE_W-1:0] RetireCount,
    output logic [1:0]          DbgState
);

    localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [2:0] cnt_nxt;
    logic       retire_nxt;

    logic [2:0] last_step;
    logic       is_mem;
    logic       is_halt;

    logic stall;
    logic at_last;
    logic complete;

    last_step_lut u_lut (
        .InsM     (InsM),
        .InsL     (InsL),
        .LastStep (last_step),
        .IsMem    (is_mem),
        .IsHalt   (is_halt)
    );

    // Step 0 waits on the instruction fetch; memory-class step 3 waits on data.
    assign stall = !MemReady &&
                   ((Cnt == STEP_FETCH) || ((Cnt == STEP_MEM) && is_mem));
    // The decode is meaningless during fetch, so step 0 is never a last step.
    assign at_last  = (Cnt != STEP_FETCH) && (Cnt == last_step);
    assign complete = (state == ST_RUN) && at_last && !stall;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = Cnt;
        retire_nxt = 1'b0;
        if (Cnt == STEP_BAD) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = STEP_FETCH;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_nxt = STEP_FETCH;
                    if (Start) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (complete) begin
                        cnt_nxt    = STEP_FETCH;
                        retire_nxt = 1'b1;
                        if (is_halt)       state_nxt = ST_HALTED;
                        else if (StepMode) state_nxt = ST_PAUSED;
                    end else if (!stall) begin
                        cnt_nxt = Cnt + 3'd1;
                    end
                end
                ST_PAUSED: begin
                    cnt_nxt = STEP_FETCH;
                    if (StepReq || !StepMode) state_nxt = ST_RUN;
                end
                ST_HALTED: begin
                    cnt_nxt = STEP_FETCH;
                    if (Start) state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= ST_IDLE;
            Cnt         <= STEP_FETCH;
            Retire      <= 1'b0;
            RetireCount <= '0;
        end else begin
            state  <= state_nxt;
            Cnt    <= cnt_nxt;
            Retire <= retire_nxt;
            if (retire_nxt) RetireCount <= RetireCount + RETIRE_ONE;
        end
    end

    assign Running  = (state == ST_RUN);
    assign Halted   = (state == ST_HALTED);
    assign DbgState = state;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: driver tasks walk instruction traces,
// a monitor pops expected retire counts whenever Retire pulses.
module tb_step_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0, step_mode = 1'b0, step_req = 1'b0, mem_ready = 1'b1;
    logic [4:0] ins_m = 5'b0;
    logic [1:0] ins_l = 2'b0;

    logic [2:0]  cnt, cnt4;
    logic        running, halted, retire, running4, halted4, retire4;
    logic [15:0] retire_count;
    logic [3:0]  retire_count4;
    logic [1:0]  dbg_state, dbg_state4;

    step_sequencer #(.RETIRE_W(16)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .StepMode(step_mode), .StepReq(step_req),
        .MemReady(mem_ready), .InsM(ins_m), .InsL(ins_l), .Cnt(cnt), .Running(running),
        .Halted(halted), .Retire(retire), .RetireCount(retire_count), .DbgState(dbg_state)
    );

    step_sequencer #(.RETIRE_W(4)) dut4 (
        .Clk(clk), .Rst(rst), .Start(start), .StepMode(step_mode), .StepReq(step_req),
        .MemReady(mem_ready), .InsM(ins_m), .InsL(ins_l), .Cnt(cnt4), .Running(running4),
        .Halted(halted4), .Retire(retire4), .RetireCount(retire_count4), .DbgState(dbg_state4)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int          exp_count = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        prev_retire = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every Retire pulse must match the next queued retire count.
    always @(negedge clk) begin
        if (!rst) begin
            if (retire) begin
                chk("retire_not_back_to_back", {31'b0, prev_retire}, 32'd0);
                chk("retire_pair", {31'b0, retire4}, 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    chk("retire_count", {16'b0, retire_count}, {16'b0, e});
                    chk("retire_count_w4", {28'b0, retire_count4}, {28'b0, e[3:0]});
                end
            end
            prev_retire = retire;
        end else begin
            prev_retire = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // tr holds the expected Cnt after each edge, one nibble per edge (edge 0 in
    // the low nibble); mr holds MemReady for each edge, bit 0 first.
    task automatic run_seq(input string nm, input logic [4:0] m, input logic [1:0] l,
                           input int n, input logic [7:0] mr, input logic [31:0] tr,
                           input int n_ret);
        ins_m = m;
        ins_l = l;
        for (int k = 0; k < n_ret; k++) begin
            exp_count++;
            exp_q.push_back(exp_count[15:0]);
        end
        for (int i = 0; i < n; i++) begin
            mem_ready = mr[i];
            tick();
            chk($sformatf("%s_cnt%0d", nm, i), {29'b0, cnt}, {29'b0, tr[4*i +: 3]});
        end
        mem_ready = 1'b1;
    endtask

    task automatic chk_state(input string nm, input logic [1:0] st);
        chk({nm, "_state"}, {30'b0, dbg_state}, {30'b0, st});
        chk({nm, "_running"}, {31'b0, running}, {31'b0, (st == 2'd1)});
        chk({nm, "_halted"}, {31'b0, halted}, {31'b0, (st == 2'd3)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        tick();
        chk("rst_cnt", {29'b0, cnt}, 32'd0);
        chk("rst_retire", {31'b0, retire}, 32'd0);
        chk("rst_retire_count", {16'b0, retire_count}, 32'd0);
        chk_state("rst", 2'd0);
        rst = 1'b0;
        tick();
        tick();
        chk_state("idle", 2'd0);
        chk("idle_cnt", {29'b0, cnt}, 32'd0);

        pulse_start();
        chk_state("start", 2'd1);
        chk("start_cnt", {29'b0, cnt}, 32'd0);

        run_seq("add",      5'b00000, 2'b00, 5, 8'b0001_1111, 32'h0004_3210 >> 4 | 32'h0000_0000, 1);
        run_seq("add_fstl", 5'b00000, 2'b00, 7, 8'b0111_1100, 32'h0432_100, 1);
        run_seq("store",    5'b00101, 2'b00, 7, 8'b0100_0111, 32'h0333_321, 1);
        run_seq("load",     5'b00011, 2'b00, 6, 8'b0011_0101, 32'h0043_321, 1);
        run_seq("cmp",      5'b00110, 2'b01, 3, 8'b0000_0111, 32'h0000_021, 1);
        run_seq("grp6_st",  5'b00110, 2'b00, 5, 8'b0001_0111, 32'h0003_321, 1);
        run_seq("load1",    5'b00100, 2'b11, 5, 8'b0001_1111, 32'h0004_321, 1);
        run_seq("out",      5'b11100, 2'b00, 2, 8'b0000_0011, 32'h0000_001, 1);
        run_seq("jumps",    5'b10010, 2'b00, 6, 8'b0011_1111, 32'h0010_101, 3);

        // HALT wins over StepMode; StepReq must not wake it
        step_mode = 1'b1;
        run_seq("halt",     5'b11100, 2'b01, 3, 8'b0000_0111, 32'h0000_021, 1);
        chk_state("halted", 2'd3);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        chk_state("halt_stepreq", 2'd3);
        chk("halt_cnt", {29'b0, cnt}, 32'd0);
        pulse_start();
        chk_state("resume", 2'd1);
        chk("resume_cnt", {29'b0, cnt}, 32'd0);

        // single-step mode with three ADDs
        run_seq("step_add1", 5'b00000, 2'b00, 5, 8'b0001_1111, 32'h0004_321, 1);
        chk_state("paused1", 2'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_state("paused_hold", 2'd2);
        chk("paused_cnt", {29'b0, cnt}, 32'd0);
        for (int j = 2; j <= 3; j++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            chk_state($sformatf("stepreq%0d", j), 2'd1);
            run_seq($sformatf("step_add%0d", j), 5'b00000, 2'b00, 5, 8'b0001_1111, 32'h0004_321, 1);
            chk_state($sformatf("paused%0d", j), 2'd2);
        end

        // StepReq together with StepMode falling: one instruction, then keep running
        step_req = 1'b1;
        step_mode = 1'b0;
        tick();
        step_req = 1'b0;
        run_seq("both_add", 5'b00000, 2'b00, 5, 8'b0001_1111, 32'h0004_321, 1);
        chk_state("both_run", 2'd1);
        run_seq("both_jmp", 5'b10010, 2'b00, 2, 8'b0000_0011, 32'h0000_001, 1);

        // asynchronous reset mid-load at step 3
        run_seq("ld_rst", 5'b00011, 2'b00, 3, 8'b0000_0111, 32'h0000_321, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_cnt", {29'b0, cnt}, 32'd0);
        chk("midrst_retire", {31'b0, retire}, 32'd0);
        chk("midrst_count", {16'b0, retire_count}, 32'd0);
        chk("midrst_count4", {28'b0, retire_count4}, 32'd0);
        chk_state("midrst", 2'd0);
        chk("midrst_queue_empty", exp_q.size(), 32'd0);
        exp_count = 0;
        tick();
        rst = 1'b0;
        tick();
        chk_state("post_rst_idle", 2'd0);

        // 16 jumps: the 4-bit counter wraps back to 0
        pulse_start();
        for (int j = 0; j < 8; j++)
            run_seq("wrap_jmp", 5'b10110, 2'b10, 4, 8'b0000_1111, 32'h0000_0101, 2);
        @(negedge clk);
        chk("wrap_count4", {28'b0, retire_count4}, 32'd0);
        chk("wrap_count16", {16'b0, retire_count}, 32'd16);
        #1 rst = 1'b1;
        tick();
        tick();
        chk("end_queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
